ahb2apb_bridge: RTL and testbench
=================================

// Module: ahb2apb_bridge
// PURPOSE
//  Single-clock AHB(-Lite/AHB5) slave to APB master bridge. Converts each selected AHB
//  NONSEQ/SEQ transfer into one APB SETUP+ACCESS transaction and stalls the AHB data phase
//  (hreadyout_o low) until the APB slave completes. Sits between the system AHB fabric and
//  the low-speed APB peripheral segment. One transfer in flight; no buffering, no errors.
// PARAMETERS
//  ADDR_WIDTH    32  address width, AHB and APB
//  HBURST_WIDTH  3   hburst_i width (accepted, ignored)
//  HPROT_WIDTH   4   hprot_i width (accepted, ignored)
//  DATA_WIDTH    32  data width; strobe width = DATA_WIDTH/8
// PORTS
//  hclk_i       in   1              single clock for AHB and APB sides
//  hresetn_i    in   1              reset, synchronous, active-low
//  haddr_i      in   ADDR_WIDTH     AHB address (address phase)
//  hburst_i     in   HBURST_WIDTH   burst type, ignored
//  hmastlock_i  in   1              ignored
//  hsel_i       in   1              slave select
//  hprot_i      in   HPROT_WIDTH    ignored
//  hsize_i      in   3              transfer size, ignored (full-width APB access)
//  hnonsec_i    in   1              ignored
//  hexcl_i      in   1              exclusive request, ignored (never EXOKAY)
//  hmaster_i    in   4              master ID, ignored
//  htrans_i     in   2              00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwdata_i     in   DATA_WIDTH     write data (data phase)
//  hwstrb_i     in   DATA_WIDTH/8   write strobes (data phase)
//  hwrite_i     in   1              1 write, 0 read
//  hrdata_o     out  DATA_WIDTH     read data, registered
//  hready_o     out  1              copy of hreadyout_o
//  hreadyout_o  out  1              data-phase ready, registered
//  hresp_o      out  1              always 0 (OKAY)
//  hexokay_o    out  1              always 0
//  paddr_o      out  ADDR_WIDTH     APB address, registered
//  psel_o       out  1              APB select
//  penabe_o     out  1              APB enable (PENABLE)
//  pwrite_o     out  1              APB direction, registered
//  pwdata_o     out  DATA_WIDTH     = hwdata_i (master holds it stable while stalled)
//  pstrb_o      out  DATA_WIDTH/8   = hwstrb_i when pwrite_o=1, else 0
//  prdata_i     in   DATA_WIDTH     APB read data
//  pready_i     in   1              APB ready
// BEHAVIOUR
//  - All flops sample on posedge hclk_i; reset only when hresetn_i=0 at that edge.
//  - Reset values: state IDLE, psel_o=0, penabe_o=0, paddr_o=0, pwrite_o=0, hrdata_o=0,
//    hreadyout_o=hready_o=1; hresp_o, hexokay_o constant 0.
//  - accept = hsel_i & htrans_i[1] & hreadyout_o. On accept edge: latch paddr_o<=haddr_i,
//    pwrite_o<=hwrite_i; state->SETUP, psel_o<=1, penabe_o<=0, hreadyout_o<=0.
//  - SETUP (1 cycle): next edge -> ACCESS, penabe_o<=1.
//  - ACCESS: hold psel/penable/paddr/pwrite while pready_i=0 (unbounded wait).
//    pready_i=1 at edge: psel_o<=0, penabe_o<=0, hreadyout_o<=1, state->IDLE;
//    if read, hrdata_o<=prdata_i; writes leave hrdata_o unchanged.
//  - Latency: address phase cycle A, SETUP A+1, ACCESS A+2, with pready_i=1 the data phase
//    ends in A+3 (hreadyout_o=1, hrdata_o valid): 2 AHB wait states minimum, +1 per APB wait.
//  - Back-to-back: in completion cycle (IDLE, hreadyout_o=1) a new NONSEQ/SEQ is accepted
//    directly -> SETUP next edge; no idle APB cycle required beyond that.
//  - htrans IDLE/BUSY or hsel_i=0: no APB activity, hreadyout_o stays 1, zero-wait OKAY.
//  - Reset mid-transfer: APB aborted, all outputs to reset values on that edge.
//  - States: IDLE, SETUP, ACCESS (2-bit encoding); illegal encodings -> IDLE.
// TESTING
//  1 Reset held 2 cycles -> psel_o=0, penabe_o=0, hreadyout_o=1, hrdata_o=0, hresp_o=0.
//  2 Write haddr=0x0000_1004, hwdata=0xDEADBEEF, pready=1 -> SETUP/ACCESS on A+1/A+2,
//    paddr_o=0x1004, pwrite_o=1, pwdata_o=0xDEADBEEF, pstrb_o=0xF, hreadyout_o=1 at A+3.
//  3 Read 0x2000, pready low 3 ACCESS cycles, prdata=0x12345678 -> 5 wait states,
//    hrdata_o=0x12345678 at completion, psel held stable throughout.
//  4 Back-to-back write 0x10 then read 0x14 -> second SETUP in cycle after first completion.
//  5 hsel_i=1, htrans=IDLE then BUSY -> psel_o stays 0, hreadyout_o stays 1.
//  6 hresetn_i=0 during ACCESS -> next edge psel_o=0, penabe_o=0, hreadyout_o=1.

Source files
------------

// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle for the AHB-to-APB bridge: AHB slave-side and APB master-side signals.
// The slave modport is the bridge's view; master is the view of the surrounding fabric.
interface ahb2apb_bridge_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned HBURST_WIDTH = 3,
  parameter int unsigned HPROT_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]   haddr_i;
  logic [HBURST_WIDTH-1:0] hburst_i;
  logic                    hmastlock_i;
  logic                    hsel_i;
  logic [HPROT_WIDTH-1:0]  hprot_i;
  logic [2:0]              hsize_i;
  logic                    hnonsec_i;
  logic                    hexcl_i;
  logic [3:0]              hmaster_i;
  logic [1:0]              htrans_i;
  logic [DATA_WIDTH-1:0]   hwdata_i;
  logic [STRB_WIDTH-1:0]   hwstrb_i;
  logic                    hwrite_i;
  logic [DATA_WIDTH-1:0]   hrdata_o;
  logic                    hready_o;
  logic                    hreadyout_o;
  logic                    hresp_o;
  logic                    hexokay_o;
  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic                    psel_o;
  logic                    penabe_o;
  logic                    pwrite_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [STRB_WIDTH-1:0]   pstrb_o;
  logic [DATA_WIDTH-1:0]   prdata_i;
  logic                    pready_i;

  modport slave (
    input  haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i, hnonsec_i,
           hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i, hwrite_i,
           prdata_i, pready_i,
    output hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
           paddr_o, psel_o, penabe_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport master (
    output haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i, hnonsec_i,
           hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i, hwrite_i,
           prdata_i, pready_i,
    input  hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
           paddr_o, psel_o, penabe_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// Single-clock AHB slave to APB master bridge: one transfer in flight, AHB data phase
// stalled until the APB access completes.
module ahb2apb_bridge #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned HBURST_WIDTH = 3,
  parameter int unsigned HPROT_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input logic               hclk_i,
  input logic               hresetn_i,
  ahb2apb_bridge_if.slave   bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  logic [1:0]            state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0] hrdata_q,    hrdata_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  accept;

  assign accept = bus.hsel_i & bus.htrans_i[1] & hreadyout_q;

  // State and registered outputs
  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    hrdata_d    = hrdata_q;
    hreadyout_d = hreadyout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SETUP;
          paddr_d     = bus.haddr_i;
          pwrite_d    = bus.hwrite_i;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          hreadyout_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.pready_i) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          hreadyout_d = 1'b1;
          if (!pwrite_q) begin
            hrdata_d = bus.prdata_i;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
    endcase
  end

  assign bus.hrdata_o    = hrdata_q;
  assign bus.hreadyout_o = hreadyout_q;
  assign bus.hready_o    = hreadyout_q;
  assign bus.hresp_o     = 1'b0;
  assign bus.hexokay_o   = 1'b0;
  assign bus.paddr_o     = paddr_q;
  assign bus.psel_o      = psel_q;
  assign bus.penabe_o    = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  // The AHB master holds write data stable while the data phase is stalled
  assign bus.pwdata_o    = bus.hwdata_i;
  assign bus.pstrb_o     = pwrite_q ? bus.hwstrb_i : STRB_WIDTH'(0);

  logic [HBURST_WIDTH+HPROT_WIDTH-1:0] unused_attr;
  logic                                unused_misc;
  assign unused_attr = {bus.hburst_i, bus.hprot_i};
  assign unused_misc = ^{bus.hmastlock_i, bus.hsize_i, bus.hnonsec_i, bus.hexcl_i,
                         bus.hmaster_i, bus.htrans_i[0]};
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge.
module tb_ahb2apb_bridge;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   waits;

  ahb2apb_bridge_if bus ();

  ahb2apb_bridge dut (
    .hclk_i    (clk),
    .hresetn_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.haddr_i     = '0;
    bus.hburst_i    = '0;
    bus.hmastlock_i = 1'b0;
    bus.hsel_i      = 1'b0;
    bus.hprot_i     = '0;
    bus.hsize_i     = 3'b010;
    bus.hnonsec_i   = 1'b0;
    bus.hexcl_i     = 1'b0;
    bus.hmaster_i   = '0;
    bus.htrans_i    = 2'b00;
    bus.hwdata_i    = '0;
    bus.hwstrb_i    = '0;
    bus.hwrite_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;

    // 1: reset held for two cycles
    step();
    step();
    chk("rst_psel", 32'(bus.psel_o), 32'd0);
    chk("rst_penable", 32'(bus.penabe_o), 32'd0);
    chk("rst_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    chk("rst_hready", 32'(bus.hready_o), 32'd1);
    chk("rst_hrdata", bus.hrdata_o, 32'h0);
    chk("rst_hresp", 32'(bus.hresp_o), 32'd0);
    chk("rst_hexokay", 32'(bus.hexokay_o), 32'd0);
    chk("rst_paddr", bus.paddr_o, 32'h0);
    rst_n = 1'b1;

    // 2: single write, pready high
    bus.hsel_i   = 1'b1;
    bus.haddr_i  = 32'h0000_1004;
    bus.hwrite_i = 1'b1;
    bus.htrans_i = 2'b10;
    bus.pready_i = 1'b1;
    step();
    chk("wr_setup_psel", 32'(bus.psel_o), 32'd1);
    chk("wr_setup_penable", 32'(bus.penabe_o), 32'd0);
    chk("wr_setup_hreadyout", 32'(bus.hreadyout_o), 32'd0);
    chk("wr_paddr", bus.paddr_o, 32'h0000_1004);
    chk("wr_pwrite", 32'(bus.pwrite_o), 32'd1);
    bus.htrans_i = 2'b00;
    bus.haddr_i  = 32'h0;
    bus.hwrite_i = 1'b0;
    bus.hwdata_i = 32'hDEAD_BEEF;
    bus.hwstrb_i = 4'hF;
    #1;
    chk("wr_pwdata", bus.pwdata_o, 32'hDEAD_BEEF);
    chk("wr_pstrb", 32'(bus.pstrb_o), 32'hF);
    step();
    chk("wr_access_psel", 32'(bus.psel_o), 32'd1);
    chk("wr_access_penable", 32'(bus.penabe_o), 32'd1);
    chk("wr_access_hreadyout", 32'(bus.hreadyout_o), 32'd0);
    step();
    chk("wr_done_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    chk("wr_done_psel", 32'(bus.psel_o), 32'd0);
    chk("wr_done_penable", 32'(bus.penabe_o), 32'd0);
    chk("wr_hrdata_unchanged", bus.hrdata_o, 32'h0);

    // 3: read with three low-pready ACCESS cycles
    bus.haddr_i  = 32'h0000_2000;
    bus.hwrite_i = 1'b0;
    bus.htrans_i = 2'b10;
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'h1234_5678;
    waits = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        bus.htrans_i = 2'b00;
        bus.haddr_i  = 32'h0;
        #1;
        chk("rd_pstrb_zero", 32'(bus.pstrb_o), 32'd0);
        chk("rd_pwrite", 32'(bus.pwrite_o), 32'd0);
      end
      if (bus.hreadyout_o === 1'b1) break;
      waits++;
      chk("rd_psel_held", 32'(bus.psel_o), 32'd1);
      chk("rd_paddr_held", bus.paddr_o, 32'h0000_2000);
      bus.pready_i = (k >= 5) ? 1'b1 : 1'b0;
    end
    chk("rd_wait_states", 32'(waits), 32'd5);
    chk("rd_hrdata", bus.hrdata_o, 32'h1234_5678);
    chk("rd_done_psel", 32'(bus.psel_o), 32'd0);

    // 4: back-to-back write 0x10 then SEQ read 0x14
    bus.haddr_i  = 32'h0000_0010;
    bus.hwrite_i = 1'b1;
    bus.htrans_i = 2'b10;
    bus.pready_i = 1'b1;
    step();
    bus.htrans_i = 2'b00;
    bus.hwdata_i = 32'h0000_00AA;
    step();
    step();
    chk("b2b_first_done", 32'(bus.hreadyout_o), 32'd1);
    bus.haddr_i  = 32'h0000_0014;
    bus.hwrite_i = 1'b0;
    bus.htrans_i = 2'b11;
    bus.prdata_i = 32'hCAFE_F00D;
    step();
    chk("b2b_setup_psel", 32'(bus.psel_o), 32'd1);
    chk("b2b_setup_penable", 32'(bus.penabe_o), 32'd0);
    chk("b2b_paddr", bus.paddr_o, 32'h0000_0014);
    chk("b2b_pwrite", 32'(bus.pwrite_o), 32'd0);
    bus.htrans_i = 2'b00;
    step();
    step();
    chk("b2b_hrdata", bus.hrdata_o, 32'hCAFE_F00D);
    chk("b2b_done_hreadyout", 32'(bus.hreadyout_o), 32'd1);

    // 5: IDLE, BUSY and deselected transfers produce no APB activity
    bus.haddr_i  = 32'h0000_0030;
    bus.htrans_i = 2'b00;
    step();
    chk("idle_psel", 32'(bus.psel_o), 32'd0);
    chk("idle_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    bus.htrans_i = 2'b01;
    step();
    chk("busy_psel", 32'(bus.psel_o), 32'd0);
    chk("busy_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    bus.hsel_i   = 1'b0;
    bus.htrans_i = 2'b10;
    step();
    chk("nosel_psel", 32'(bus.psel_o), 32'd0);
    chk("nosel_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    chk("nosel_paddr", bus.paddr_o, 32'h0000_0014);

    // 6: reset asserted during ACCESS
    bus.hsel_i   = 1'b1;
    bus.haddr_i  = 32'h0000_0040;
    bus.htrans_i = 2'b10;
    bus.pready_i = 1'b0;
    step();
    bus.htrans_i = 2'b00;
    step();
    chk("rstmid_access_penable", 32'(bus.penabe_o), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstmid_psel", 32'(bus.psel_o), 32'd0);
    chk("rstmid_penable", 32'(bus.penabe_o), 32'd0);
    chk("rstmid_hreadyout", 32'(bus.hreadyout_o), 32'd1);
    chk("rstmid_paddr", bus.paddr_o, 32'h0);
    chk("rstmid_hrdata", bus.hrdata_o, 32'h0);
    rst_n = 1'b1;
    bus.pready_i = 1'b1;
    step();
    chk("post_rst_psel", 32'(bus.psel_o), 32'd0);
    chk("post_rst_hreadyout", 32'(bus.hreadyout_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
